// File: rtl/multiplier_arbiter_pkg.sv
// Shared types for the multiplier arbiter: FSM state encoding and index/counter width helper.
package multiplier_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StLaunch  = 2'd1,
        StWait    = 2'd2,
        StRespond = 2'd3
    } state_e;

    // Width able to hold values 0..n-1, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multiplier_arbiter_if.sv
// Client and multiplier handshake bundle; slave is the arbiter's view, master the environment's.
interface multiplier_arbiter_if #(
    parameter int unsigned BITS       = 4,
    parameter int unsigned REQUESTERS = 3
);
    logic [REQUESTERS-1:0]      i_request;
    logic [REQUESTERS*BITS-1:0] i_multiplicand;
    logic [REQUESTERS*BITS-1:0] i_multiplier;
    logic [REQUESTERS-1:0]      o_grant;
    logic [REQUESTERS-1:0]      o_done;
    logic [2*BITS-1:0]          o_product;
    logic                       o_error;
    logic                       o_busy;
    logic                       o_mul_start;
    logic [BITS-1:0]            o_mul_a;
    logic [BITS-1:0]            o_mul_b;
    logic                       i_mul_finished;
    logic [2*BITS-1:0]          i_mul_product;

    modport slave (
        input  i_request, i_multiplicand, i_multiplier, i_mul_finished, i_mul_product,
        output o_grant, o_done, o_product, o_error, o_busy, o_mul_start, o_mul_a, o_mul_b
    );

    modport master (
        output i_request, i_multiplicand, i_multiplier, i_mul_finished, i_mul_product,
        input  o_grant, o_done, o_product, o_error, o_busy, o_mul_start, o_mul_a, o_mul_b
    );
endinterface

// File: rtl/multiplier_arbiter_rr_priority_select.sv
// Round-robin pick: first set request bit searching upward from last+1 with wrap.
module multiplier_arbiter_rr_priority_select
    import multiplier_arbiter_pkg::*;
#(
    parameter int unsigned N = 3,
    localparam int unsigned IdxW = idx_width(N)
) (
    input  logic [N-1:0]    i_request,
    input  logic [IdxW-1:0] i_last,
    output logic [N-1:0]    o_grant,
    output logic [IdxW-1:0] o_index,
    output logic            o_any
);

    int unsigned w_k;

    always_comb begin
        o_grant = '0;
        o_index = '0;
        o_any   = 1'b0;
        w_k     = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            w_k = (32'(i_last) + i) % N;
            if (!o_any && i_request[w_k[IdxW-1:0]]) begin
                o_any                   = 1'b1;
                o_index                 = w_k[IdxW-1:0];
                o_grant[w_k[IdxW-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multiplier_arbiter.sv
// Shares one sequential multiplier among REQUESTERS clients: arbitrate, launch, wait with
// timeout guard, then return the product and a done pulse to the owning client.
module multiplier_arbiter
    import multiplier_arbiter_pkg::*;
#(
    parameter int unsigned BITS       = 4,
    parameter int unsigned REQUESTERS = 3,
    parameter int unsigned TIMEOUT    = 16
) (
    input logic                  i_clock,
    input logic                  i_reset,
    multiplier_arbiter_if.slave  bus
);

    localparam int unsigned IdxW = idx_width(REQUESTERS);
    localparam int unsigned CntW = idx_width(TIMEOUT);

    state_e                r_state;
    state_e                w_state_next;
    logic [REQUESTERS-1:0] r_grant;
    logic [IdxW-1:0]       r_owner;
    logic [IdxW-1:0]       r_last;
    logic [CntW-1:0]       r_count;
    logic                  r_error;
    logic [BITS-1:0]       r_mul_a;
    logic [BITS-1:0]       r_mul_b;
    logic [2*BITS-1:0]     r_product;

    logic [REQUESTERS-1:0] w_sel_grant;
    logic [IdxW-1:0]       w_sel_index;
    logic                  w_sel_any;
    logic                  w_timeout;

    multiplier_arbiter_rr_priority_select #(
        .N (REQUESTERS)
    ) u_select (
        .i_request (bus.i_request),
        .i_last    (r_last),
        .o_grant   (w_sel_grant),
        .o_index   (w_sel_index),
        .o_any     (w_sel_any)
    );

    assign w_timeout = (r_count == CntW'(TIMEOUT - 1));

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:    if (w_sel_any) w_state_next = StLaunch;
            StLaunch:  w_state_next = StWait;
            // finished takes priority over a coincident timeout
            StWait:    if (bus.i_mul_finished || w_timeout) w_state_next = StRespond;
            StRespond: w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_grant   <= '0;
            r_owner   <= '0;
            r_last    <= IdxW'(REQUESTERS - 1);
            r_count   <= '0;
            r_error   <= 1'b0;
            r_mul_a   <= '0;
            r_mul_b   <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_sel_any) begin
                        r_grant <= w_sel_grant;
                        r_owner <= w_sel_index;
                        r_mul_a <= bus.i_multiplicand[32'(w_sel_index) * BITS +: BITS];
                        r_mul_b <= bus.i_multiplier[32'(w_sel_index) * BITS +: BITS];
                    end
                end
                StLaunch: r_count <= '0;
                StWait: begin
                    if (bus.i_mul_finished) begin
                        r_product <= bus.i_mul_product;
                    end else if (w_timeout) begin
                        r_error <= 1'b1;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                StRespond: begin
                    r_last  <= r_owner;
                    r_error <= 1'b0;
                    r_grant <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_grant     = r_grant;
    assign bus.o_done      = (r_state == StRespond) ? r_grant : '0;
    assign bus.o_error     = (r_state == StRespond) && r_error;
    assign bus.o_busy      = (r_state != StIdle);
    assign bus.o_mul_start = (r_state == StLaunch);
    assign bus.o_mul_a     = r_mul_a;
    assign bus.o_mul_b     = r_mul_b;
    assign bus.o_product   = r_product;

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a job-level model.
module tb_multiplier_arbiter;

    localparam int unsigned BITS    = 4;
    localparam int unsigned REQ     = 3;
    localparam int unsigned TIMEOUT = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    multiplier_arbiter_if #(.BITS(BITS), .REQUESTERS(REQ)) bus ();

    multiplier_arbiter #(
        .BITS       (BITS),
        .REQUESTERS (REQ),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .i_clock (clock),
        .i_reset (reset),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int g_delay = 4;   // cycles from start to finished; 0 = never finishes
    int mdl_rem;

    // Stand-in sequential multiplier.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.i_mul_finished <= 1'b0;
            bus.i_mul_product  <= '0;
            mdl_rem            <= 0;
        end else begin
            bus.i_mul_finished <= 1'b0;
            if (bus.o_mul_start) begin
                if (g_delay == 1) begin
                    bus.i_mul_finished <= 1'b1;
                    bus.i_mul_product  <= 8'(bus.o_mul_a) * 8'(bus.o_mul_b);
                end
                mdl_rem <= (g_delay > 1) ? g_delay - 1 : 0;
            end else if (mdl_rem == 1) begin
                bus.i_mul_finished <= 1'b1;
                bus.i_mul_product  <= 8'(bus.o_mul_a) * 8'(bus.o_mul_b);
                mdl_rem            <= 0;
            end else if (mdl_rem > 1) begin
                mdl_rem <= mdl_rem - 1;
            end
        end
    end

    // Job-level reference: 0 idle, 1 launch, 2 waiting, 3 responding.
    int              m_phase;
    int              m_owner;
    int              m_last;
    int              m_wait;
    logic            m_err;
    logic [7:0]      m_prod;
    logic [BITS-1:0] m_a;
    logic [BITS-1:0] m_b;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_owner = 0;
        m_last  = REQ - 1;
        m_wait  = 0;
        m_err   = 1'b0;
        m_prod  = '0;
        m_a     = '0;
        m_b     = '0;
    endtask

    task automatic model_edge(input logic [REQ-1:0] req, input logic [REQ*BITS-1:0] mc,
                              input logic [REQ*BITS-1:0] mp, input logic fin);
        logic [REQ-1:0]      rtmp;
        logic [REQ*BITS-1:0] otmp;
        int                  k;
        case (m_phase)
            0: begin
                for (int i = 1; i <= REQ; i++) begin
                    k    = (m_last + i) % REQ;
                    rtmp = req >> k;
                    if (m_phase == 0 && rtmp[0]) begin
                        m_owner = k;
                        otmp    = mc >> (k * BITS);
                        m_a     = otmp[BITS-1:0];
                        otmp    = mp >> (k * BITS);
                        m_b     = otmp[BITS-1:0];
                        m_phase = 1;
                    end
                end
            end
            1: begin
                m_phase = 2;
                m_wait  = 0;
            end
            2: begin
                if (fin) begin
                    m_prod  = 8'(m_a) * 8'(m_b);
                    m_err   = 1'b0;
                    m_phase = 3;
                end else begin
                    m_wait++;
                    if (m_wait == TIMEOUT) begin
                        m_err   = 1'b1;
                        m_phase = 3;
                    end
                end
            end
            default: begin
                m_phase = 0;
                m_last  = m_owner;
                m_err   = 1'b0;
            end
        endcase
    endtask

    task automatic compare_all();
        logic [REQ-1:0] oh;
        oh = REQ'(1) << m_owner;
        check_eq("grant", 32'(bus.o_grant), (m_phase != 0) ? 32'(oh) : 32'd0);
        check_eq("done", 32'(bus.o_done), (m_phase == 3) ? 32'(oh) : 32'd0);
        check_eq("error", 32'(bus.o_error), 32'(m_phase == 3 && m_err));
        check_eq("busy", 32'(bus.o_busy), 32'(m_phase != 0));
        check_eq("start", 32'(bus.o_mul_start), 32'(m_phase == 1));
        check_eq("product", 32'(bus.o_product), 32'(m_prod));
        check_eq("mul_a", 32'(bus.o_mul_a), 32'(m_a));
        check_eq("mul_b", 32'(bus.o_mul_b), 32'(m_b));
    endtask

    // Called just after a rising edge: drive inputs, advance one clock, check.
    task automatic step(input logic [REQ-1:0] req, input logic [REQ*BITS-1:0] mc,
                        input logic [REQ*BITS-1:0] mp);
        logic fin;
        bus.i_request      = req;
        bus.i_multiplicand = mc;
        bus.i_multiplier   = mp;
        fin                = bus.i_mul_finished;
        @(posedge clock);
        #1;
        model_edge(req, mc, mp, fin);
        compare_all();
    endtask

    task automatic idle_steps(input int n, input logic [REQ*BITS-1:0] mc,
                              input logic [REQ*BITS-1:0] mp);
        for (int i = 0; i < n; i++) step('0, mc, mp);
    endtask

    task automatic pulse_reset();
        bus.i_request = '0;
        reset         = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clock);
        #1;
        compare_all();
        reset = 1'b1;
    endtask

    logic [REQ*BITS-1:0] mc;
    logic [REQ*BITS-1:0] mp;

    initial begin
        bus.i_request      = '0;
        bus.i_multiplicand = '0;
        bus.i_multiplier   = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        compare_all();
        reset = 1'b1;

        // Single request from client 0: 5*3 with a 4-cycle multiplier.
        mc = {4'd0, 4'd0, 4'd5};
        mp = {4'd0, 4'd0, 4'd3};
        g_delay = 4;
        step(3'b001, mc, mp);
        idle_steps(8, mc, mp);

        // All clients requesting continuously: rotation 001,010,100,001.
        mc = {4'd7, 4'd4, 4'd2};
        mp = {4'd7, 4'd5, 4'd3};
        g_delay = 3;
        for (int i = 0; i < 24; i++) step(3'b111, mc, mp);
        idle_steps(6, mc, mp);

        // Timeout: multiplier never answers, product must hold.
        g_delay = 0;
        step(3'b001, mc, mp);
        idle_steps(21, mc, mp);

        // Finished lands on the final wait cycle: accepted without error.
        g_delay = TIMEOUT;
        step(3'b010, mc, mp);
        idle_steps(21, mc, mp);

        // Client 1 withdraws its request right after the grant.
        mc = {4'd0, 4'd15, 4'd0};
        mp = {4'd0, 4'd15, 4'd0};
        g_delay = 5;
        step(3'b010, mc, mp);
        step(3'b010, mc, mp);
        idle_steps(10, mc, mp);

        // Reset in the middle of a wait, then client 0 is served first.
        mc = {4'd9, 4'd6, 4'd11};
        mp = {4'd8, 4'd2, 4'd13};
        g_delay = 8;
        step(3'b100, mc, mp);
        step(3'b100, mc, mp);
        step(3'b000, mc, mp);
        pulse_reset();
        g_delay = 4;
        step(3'b111, mc, mp);
        idle_steps(9, mc, mp);

        // Random traffic, delays spanning fast, timeout-coincident, late and never.
        for (int i = 0; i < 600; i++) begin
            g_delay = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 18));
            mc      = 12'($urandom);
            mp      = 12'($urandom);
            step(3'($urandom_range(0, 7)), mc, mp);
        end
        idle_steps(24, mc, mp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multiplier_arbiter.md
Name: multiplier_arbiter

Overview:
Round-robin arbiter and sequencer that shares one sequential multiplier (start/finished handshake, BITS-wide operands, 2*BITS product) among REQUESTERS clients. It latches the winning client's operands and pulses the multiplier start. It waits for finished, with a timeout guard, then returns the product and a one-cycle done pulse to that client. It sits between client logic and the single multiplier instance.

Parameters:
BITS, 4, operand width; product is 2*BITS.
REQUESTERS, 3, number of clients (>=2).
TIMEOUT, 16, max cycles spent in WAIT before an error is reported (>=BITS+1).

Ports:
i_clock  in  1  rising-edge clock.
i_reset  in  1  asynchronous, active-low reset; 0 = reset.
i_request  in  REQUESTERS  per-client request level.
i_multiplicand  in  REQUESTERS*BITS  flattened operands; client k at [k*BITS +: BITS].
i_multiplier  in  REQUESTERS*BITS  flattened operands, same packing.
o_grant  out  REQUESTERS  one-hot owner, 0 when idle.
o_done  out  REQUESTERS  one-cycle pulse to the owner on completion.
o_product  out  2*BITS  result, valid with o_done; holds until the next completion.
o_error  out  1  pulses with o_done when the timeout fired.
o_busy  out  1  high whenever the state is not IDLE.
o_mul_start  out  1  one-cycle start pulse to the multiplier.
o_mul_a  out  BITS  latched multiplicand to the multiplier.
o_mul_b  out  BITS  latched multiplier operand to the multiplier.
i_mul_finished  in  1  multiplier completion.
i_mul_product  in  2*BITS  multiplier result, sampled when i_mul_finished=1.

Behaviour:
- Reset (i_reset=0, asynchronous): state=IDLE; all outputs 0; round-robin pointer last=REQUESTERS-1, so client 0 has first priority; timeout counter 0.
- FSM states: IDLE -> LAUNCH -> WAIT -> RESPOND -> IDLE.
- IDLE:
  - If any i_request bit is set, select the first set bit searching from last+1 upward, with modulo wrap.
  - Latch that client's operands into o_mul_a/o_mul_b and set o_grant one-hot.
  - Next state is LAUNCH. With no request, stay in IDLE.
- LAUNCH: o_mul_start=1 for exactly this cycle; counter cleared; next state WAIT.
- WAIT:
  - i_mul_finished=1: register i_mul_product into o_product; next state RESPOND.
  - Otherwise counter++. When counter reaches TIMEOUT-1, set the error flag, leave o_product unchanged, and go to RESPOND.
  - A finished arriving in the same cycle as the timeout wins; no error.
- RESPOND:
  - o_done[grant]=1 for one cycle; o_error=error flag.
  - last=grant index; error flag cleared.
  - Next state IDLE; o_grant and o_busy drop on entry to IDLE.
- Latency: request sampled in IDLE at cycle 0; start at cycle 1; finished at cycle 1+n; done at cycle 2+n. The minimum idle gap is one IDLE cycle between jobs.
- Operand stability: o_mul_a/o_mul_b hold from the IDLE latch until the next grant. Client operand changes after the grant are ignored.
- Request dropped mid-operation: the job still completes and o_done is still pulsed to that client.
- Request held through o_done: treated as a new job. Round-robin serves other pending clients first.
- Simultaneous requests: strict rotation, so no client waits more than REQUESTERS-1 jobs.
- i_mul_finished asserted in IDLE/LAUNCH/RESPOND is ignored.
- Reset mid-operation: immediate return to the reset state. No done or error is issued for the aborted job.

Decomposition:
- Shared package: state encoding constants (IDLE, LAUNCH, WAIT, RESPOND) and the clog2-based width for the grant index and counter.
- One sub-module is natural: rr_priority_select, purely combinational.
  - Inputs: request vector and last index.
  - Outputs: one-hot grant, index, and an any flag.
- The FSM, counter and latches stay in the top level.

Test Plan:
- Single request: i_request=001, operands 5 and 3; the model asserts finished 4 cycles after start with product 15. Required: o_mul_start 1 cycle after the request, o_done=001 and o_product=8'd15 exactly 1 cycle after finished, o_error=0.
- All request: i_request=111 held continuously with operands (2,3),(4,5),(7,7). Required: grant order 001,010,100,001; products 6,20,49; no overlapping grants.
- Timeout: the model never asserts finished, TIMEOUT=16. Required: o_done pulse with o_error=1 exactly 17 cycles after start; o_product unchanged from its prior value.
- Finished coincident with the timeout cycle: product accepted with o_error=0.
- Request withdrawn: client 1 drops i_request the cycle after grant. Required: o_done=010 still pulsed with the correct product 15*15=225.
- Reset mid-WAIT: i_reset=0 for 1 cycle. Required: all outputs 0 immediately, with no done pulse. A later request from client 0 is served first and its done pulse arrives on schedule.
